// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing with enable-stalled counters and delayed sync/de
module vga_timing_gen #(
    parameter int HDISP    = 1280,
    parameter int HFP      = 48,
    parameter int HPW      = 112,
    parameter int HBP      = 248,
    parameter int VDISP    = 1024,
    parameter int VFP      = 1,
    parameter int VPW      = 3,
    parameter int VBP      = 38,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int PIPE_DLY = 2,
    localparam int HTOTAL  = HDISP + HFP + HPW + HBP,
    localparam int VTOTAL  = VDISP + VFP + VPW + VBP,
    localparam int XW      = $clog2(HTOTAL),
    localparam int YW      = $clog2(VTOTAL)
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic          de
);
    if (HPW < 1 || VPW < 1 || PIPE_DLY < 1 || HDISP < 1 || VDISP < 1) begin : g_bad_param
        $error("vga_timing_gen: HPW, VPW, PIPE_DLY, HDISP and VDISP must all be >= 1");
    end
    int xi, yi;
    logic x_end, y_end, de_r, hs_r, vs_r;
    logic [PIPE_DLY-1:0][2:0] pipe;
    assign xi = int'(x);
    assign yi = int'(y);
    assign x_end = xi == HTOTAL - 1;
    assign y_end = yi == VTOTAL - 1;
    assign de_r = xi < HDISP && yi < VDISP;
    assign hs_r = xi >= HDISP + HFP && xi < HDISP + HFP + HPW;
    assign vs_r = yi >= VDISP + VFP && yi < VDISP + VFP + VPW;
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            pipe <= '0;
        end else if (en) begin
            x <= x_end ? '0 : x + 1'b1;
            if (x_end) y <= y_end ? '0 : y + 1'b1;
            pipe[0] <= {de_r, hs_r, vs_r};
            for (int i = 1; i < PIPE_DLY; i++) pipe[i] <= pipe[i-1];
        end
    end
    // Priming strobes are undelayed so fetch logic can run ahead of de.
    assign line_start  = en && x == '0;
    assign frame_start = line_start && y == '0;
    assign vblank      = yi >= VDISP;
    assign de          = pipe[PIPE_DLY-1][2];
    assign hsync       = pipe[PIPE_DLY-1][1] ? HS_POL : ~HS_POL;
    assign vsync       = pipe[PIPE_DLY-1][0] ? VS_POL : ~VS_POL;
endmodule
